// File: rtl/system_button_poller_pkg.sv
// Shared types and constants for the button poller.
package system_button_poller_pkg;

  // Poll sequencer states.
  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  // Button PIO data register address and the bit carrying the pin level.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         PIO_DATA_BIT  = 0;

endpackage

// File: rtl/system_button_poll_timer.sv
// Poll prescaler: counts 0..POLL_DIV-1 while enabled, ticks on terminal count.
module system_button_poll_timer #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int            CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(POLL_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == TC);

  // Next count: restart wins, terminal count reloads to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (restart)     cnt_d = '0;
    else if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/system_button_poller.sv
// Avalon-MM button poller: periodic PIO read, debounce, press/release strobes.
module system_button_poller
  import system_button_poller_pkg::*;
#(
  parameter int          POLL_DIV         = 50000,
  parameter int          DEBOUNCE_N       = 4,
  parameter int          ACTIVE_LOW       = 1,
  // Reset value of press_count; left at 0 except to exercise the wrap.
  parameter logic [15:0] PRESS_COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        button_level,
  output logic        button_press,
  output logic        button_release,
  output logic [15:0] press_count
);

  localparam int            MW       = $clog2(DEBOUNCE_N + 1);
  localparam logic [MW-1:0] MIS_LAST = MW'(DEBOUNCE_N - 1);
  localparam logic          POL      = (ACTIVE_LOW != 0);

  state_e        state_q, state_d;
  logic          read_q, read_d;
  logic [MW-1:0] mis_q, mis_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          tick, poll_en, sample;

  // Only bit 0 of the data register is meaningful.
  logic unused_rdata;
  assign unused_rdata = &{1'b0, avm_readdata};

  // Prescaler only runs in WAIT; dropping enable parks it at 0.
  assign poll_en = enable && (state_q == ST_WAIT);

  system_button_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (poll_en),
    .restart (!enable),
    .tick    (tick)
  );

  // Normalise so 1 = pressed regardless of pin polarity.
  assign sample = avm_readdata[PIO_DATA_BIT] ^ POL;

  // Poll sequencing and debounce; an in-flight poll completes regardless of enable.
  always_comb begin
    state_d = state_q;
    read_d  = 1'b0;
    mis_d   = mis_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (tick) begin
          state_d = ST_READ;
          read_d  = 1'b1;
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_WAIT;
        if (sample == level_q) begin
          mis_d = '0;
        end else if (mis_q == MIS_LAST) begin
          mis_d   = '0;
          level_d = ~level_q;
          press_d = ~level_q;
          rel_d   = level_q;
        end else begin
          mis_d = mis_q + 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase
    if (press_d) cnt_d = cnt_q + 16'd1;
  end

  // State and output registers; reset discards any pending capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      read_q  <= 1'b0;
      mis_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= PRESS_COUNT_INIT;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      mis_q   <= mis_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign avm_address    = PIO_DATA_ADDR;
  assign avm_read       = read_q;
  assign button_level   = level_q;
  assign button_press   = press_q;
  assign button_release = rel_q;
  assign press_count    = cnt_q;

endmodule
